// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures the high time of each pulse and recovers the
// position word. It also flags malformed pulses and the loss of frames.
module servo_pulse_decoder #(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int TIMEOUT_MS = 25
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         en_i,
    input  logic         srv_i,
    output logic [N-1:0] position_o,
    output logic         valid_o,
    output logic         err_o,
    output logic         lost_o
);
    localparam int MS_CYC   = 1000000 / CLK_PER_NS;
    localparam int STEP_CYC = MS_CYC / (2 ** N);
    localparam int CW       = $clog2(MS_CYC + 1);
    localparam int SW       = (STEP_CYC > 0) ? $clog2(STEP_CYC + 1) : 1;

    localparam logic [CW-1:0] MS_LAST    = CW'(MS_CYC);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYC);
    localparam logic [N:0]    STEPS_LAST = (N+1)'(2 ** N - 1);
    localparam logic [7:0]    TIMEOUT    = 8'(TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RISE = 3'd1,
        S_BASE      = 3'd2,
        S_STEP      = 3'd3,
        S_WAIT_LOW  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [2:0]    sync_r;
    logic [1:0]    sync_vld_r;
    logic [CW-1:0] cyc_cnt_r, cyc_cnt_s;
    logic [SW-1:0] step_cyc_r, step_cyc_s;
    logic [N:0]    steps_r, steps_s;
    logic [7:0]    ms_cnt_r, ms_cnt_s;
    logic [N-1:0]  position_r, position_s;
    logic          valid_r, valid_s;
    logic          err_r, err_s;
    logic          lost_r, lost_s;
    logic          srv_sync_s, rise_s, fall_s, wrap_s;

    assign srv_sync_s = sync_r[1];
    assign rise_s     = sync_r[1] & ~sync_r[2];
    assign fall_s     = ~sync_r[1] & sync_r[2];
    assign wrap_s     = (step_cyc_r == STEP_LAST);

    // Synchroniser, edge-detect copy, and a marker for when sync_r[1] holds a real sample.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_r     <= 3'b000;
            sync_vld_r <= 2'b00;
        end else begin
            sync_r     <= {sync_r[1:0], srv_i};
            sync_vld_r <= {sync_vld_r[0], 1'b1};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r    <= S_IDLE;
            cyc_cnt_r  <= CW'(0);
            step_cyc_r <= SW'(0);
            steps_r    <= (N+1)'(0);
            ms_cnt_r   <= 8'd0;
            position_r <= N'(0);
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            lost_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            cyc_cnt_r  <= cyc_cnt_s;
            step_cyc_r <= step_cyc_s;
            steps_r    <= steps_s;
            ms_cnt_r   <= ms_cnt_s;
            position_r <= position_s;
            valid_r    <= valid_s;
            err_r      <= err_s;
            lost_r     <= lost_s;
        end
    end

    // Next-state and measurement logic; the cycle counter doubles as the ms divider while idle-low.
    always_comb begin
        state_s    = state_r;
        cyc_cnt_s  = cyc_cnt_r;
        step_cyc_s = step_cyc_r;
        steps_s    = steps_r;
        ms_cnt_s   = ms_cnt_r;
        position_s = position_r;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        lost_s     = lost_r;
        if (!en_i) begin
            state_s    = S_IDLE;
            cyc_cnt_s  = CW'(0);
            step_cyc_s = SW'(0);
            steps_s    = (N+1)'(0);
            ms_cnt_s   = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (sync_vld_r[1] && !srv_sync_s) begin
                        state_s = S_WAIT_RISE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_WAIT_RISE: begin
                    if (rise_s) begin
                        state_s   = S_BASE;
                        cyc_cnt_s = CW'(0);
                        ms_cnt_s  = 8'd0;
                    end else if (cyc_cnt_r == MS_LAST) begin
                        cyc_cnt_s = CW'(0);
                        if (ms_cnt_r < TIMEOUT) begin
                            ms_cnt_s = ms_cnt_r + 8'd1;
                        end else begin
                            ms_cnt_s = ms_cnt_r;
                        end
                        if (ms_cnt_r >= TIMEOUT - 8'd1) begin
                            lost_s = 1'b1;
                        end else begin
                            lost_s = lost_r;
                        end
                    end else begin
                        cyc_cnt_s = cyc_cnt_r + CW'(1);
                    end
                end
                S_BASE: begin
                    if (fall_s) begin
                        err_s     = 1'b1;
                        state_s   = S_WAIT_RISE;
                        cyc_cnt_s = CW'(0);
                    end else if (cyc_cnt_r == MS_LAST) begin
                        state_s    = S_STEP;
                        step_cyc_s = SW'(0);
                        steps_s    = (N+1)'(0);
                    end else begin
                        cyc_cnt_s = cyc_cnt_r + CW'(1);
                    end
                end
                S_STEP: begin
                    // Completing period 2**N is an overflow even if the pulse ends on this cycle.
                    if (wrap_s && steps_r == STEPS_LAST) begin
                        err_s     = 1'b1;
                        steps_s   = steps_r + (N+1)'(1);
                        cyc_cnt_s = CW'(0);
                        state_s   = fall_s ? S_WAIT_RISE : S_WAIT_LOW;
                    end else if (fall_s) begin
                        position_s = steps_r[N-1:0];
                        valid_s    = 1'b1;
                        lost_s     = 1'b0;
                        cyc_cnt_s  = CW'(0);
                        state_s    = S_WAIT_RISE;
                    end else if (wrap_s) begin
                        step_cyc_s = SW'(0);
                        steps_s    = steps_r + (N+1)'(1);
                    end else begin
                        step_cyc_s = step_cyc_r + SW'(1);
                    end
                end
                S_WAIT_LOW: begin
                    if (fall_s) begin
                        state_s   = S_WAIT_RISE;
                        cyc_cnt_s = CW'(0);
                    end else begin
                        state_s = S_WAIT_LOW;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    assign position_o = position_r;
    assign valid_o    = valid_r;
    assign err_o      = err_r;
    assign lost_o     = lost_r;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with scaled timing: MS_CYC=50 (base 51 cycles),
// N=4, STEP_CYC=3 (step 4 cycles), ms tick every 51 cycles, timeout 3 ticks = 153 cycles.
module tb_servo_pulse_decoder;
    localparam int CLK_PER_NS = 20000;
    localparam int N          = 4;
    localparam int TIMEOUT_MS = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic         srv;
    logic [N-1:0] position;
    logic         valid;
    logic         err;
    logic         lost;

    int   ncmp = 0;
    int   nbad = 0;
    int   cyc = 0;
    int   vcnt = 0;
    int   ecnt = 0;
    int   vcyc = 0;
    int   ecyc = 0;
    int   fall_cyc = 0;
    int   lost_rise = -1;
    logic lost_prev = 1'b1;

    servo_pulse_decoder #(
        .CLK_PER_NS(CLK_PER_NS),
        .N         (N),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .en_i      (en),
        .srv_i     (srv),
        .position_o(position),
        .valid_o   (valid),
        .err_o     (err),
        .lost_o    (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and lost-edge monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
        end
        if (err) begin
            ecnt = ecnt + 1;
            ecyc = cyc;
        end
        if (lost && !lost_prev) lost_rise = cyc;
        lost_prev = lost;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // High for h sampled edges, then low for lowc cycles; strobe counters restart per pulse.
    task automatic pulse(input int h, input int lowc);
        vcnt = 0;
        ecnt = 0;
        @(negedge clk);
        srv = 1'b1;
        repeat (h) @(negedge clk);
        srv = 1'b0;
        fall_cyc = cyc;
        repeat (lowc) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b1;
        srv  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pos",   32'(position), 32'd0);
        chk("reset_valid", 32'(valid),    32'd0);
        chk("reset_err",   32'(err),      32'd0);
        chk("reset_lost",  32'(lost),     32'd1);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // p=8: 52 + 8*4 = 84
        pulse(84, 20);
        chk("p8_vcnt", 32'(vcnt), 32'd1);
        chk("p8_ecnt", 32'(ecnt), 32'd0);
        chk("p8_pos",  32'(position), 32'd8);
        chk("p8_lat",  32'(vcyc - fall_cyc), 32'd3);
        chk("p8_lost", 32'(lost), 32'd0);

        pulse(52, 20);
        chk("p0_vcnt", 32'(vcnt), 32'd1);
        chk("p0_pos",  32'(position), 32'd0);
        pulse(112, 20);
        chk("p15_vcnt", 32'(vcnt), 32'd1);
        chk("p15_pos",  32'(position), 32'd15);
        pulse(100, 20);
        chk("p12a_pos", 32'(position), 32'd12);
        pulse(100, 20);
        chk("p12b_vcnt", 32'(vcnt), 32'd1);
        chk("p12b_pos",  32'(position), 32'd12);
        pulse(114, 20);
        chk("trunc_pos", 32'(position), 32'd15);

        // Short pulses
        pulse(30, 20);
        chk("short_ecnt", 32'(ecnt), 32'd1);
        chk("short_vcnt", 32'(vcnt), 32'd0);
        chk("short_lat",  32'(ecyc - fall_cyc), 32'd3);
        chk("short_pos",  32'(position), 32'd15);
        pulse(51, 20);
        chk("base_only_ecnt", 32'(ecnt), 32'd1);
        chk("base_only_vcnt", 32'(vcnt), 32'd0);

        // Overflow: 51 + 16*4 = 115 high edges
        pulse(115, 20);
        chk("ovf_ecnt", 32'(ecnt), 32'd1);
        chk("ovf_vcnt", 32'(vcnt), 32'd0);
        chk("ovf_lat",  32'(ecyc - fall_cyc), 32'd3);
        pulse(140, 20);
        chk("long_ecnt", 32'(ecnt), 32'd1);
        chk("long_vcnt", 32'(vcnt), 32'd0);
        chk("long_pos",  32'(position), 32'd15);

        // Good pulse after overflow, then frame loss after 153 idle cycles
        lost_rise = -1;
        pulse(84, 200);
        chk("recover_pos",  32'(position), 32'd8);
        chk("recover_vcnt", 32'(vcnt), 32'd1);
        chk("lost_level",   32'(lost), 32'd1);
        chk("lost_delay",   32'(lost_rise - vcyc), 32'd153);
        pulse(60, 20);
        chk("relock_pos",  32'(position), 32'd2);
        chk("relock_lost", 32'(lost), 32'd0);

        // Enable dropped and restored mid-pulse
        vcnt = 0;
        ecnt = 0;
        @(negedge clk);
        srv = 1'b1;
        repeat (60) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_low_pos",  32'(position), 32'd2);
        chk("en_low_lost", 32'(lost), 32'd0);
        en = 1'b1;
        repeat (20) @(negedge clk);
        srv = 1'b0;
        repeat (20) @(negedge clk);
        chk("en_mid_vcnt", 32'(vcnt), 32'd0);
        chk("en_mid_ecnt", 32'(ecnt), 32'd0);
        pulse(68, 20);
        chk("en_after_pos", 32'(position), 32'd4);

        // Reset asserted mid-pulse; the remainder of that pulse is ignored
        vcnt = 0;
        ecnt = 0;
        @(negedge clk);
        srv = 1'b1;
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_pos",  32'(position), 32'd0);
        chk("rst_mid_lost", 32'(lost), 32'd1);
        chk("rst_mid_valid", 32'(valid), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (70) @(negedge clk);
        srv = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_part_vcnt", 32'(vcnt), 32'd0);
        chk("rst_part_ecnt", 32'(ecnt), 32'd0);
        chk("rst_part_lost", 32'(lost), 32'd1);
        pulse(76, 20);
        chk("rst_after_pos",  32'(position), 32'd6);
        chk("rst_after_lost", 32'(lost), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
